// File: rtl/mshr_merge_if.sv
`default_nettype none
// ============================================================================
// Module      : mshr_merge_if
// Description : Miss / fill / issue / lookup bundle between the cache miss
//               path (master) and the MSHR (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mshr_merge_if #(
    parameter int ADDR_TAG_BITS = 20,
    parameter int DATA_BITS     = 90,
    parameter int MERGE_BITS    = 3
);
    logic                     enable;
    logic                     add;
    logic [ADDR_TAG_BITS-1:0] add_addr_tag;
    logic [DATA_BITS-1:0]     add_addr_data;
    logic                     add_addr_RW;
    logic                     add_ready;
    logic                     add_merged;
    logic                     del;
    logic [ADDR_TAG_BITS-1:0] del_addr_tag;
    logic                     del_hit;
    logic [MERGE_BITS-1:0]    del_count;
    logic                     read_next;
    logic                     read_valid;
    logic [ADDR_TAG_BITS-1:0] read_addr_tag;
    logic [DATA_BITS-1:0]     read_addr_data;
    logic                     read_RW;
    logic                     isRW_request;
    logic [ADDR_TAG_BITS-1:0] isRW_tag;
    logic                     isRW_valid;
    logic                     isRW_RW;
    logic                     full;
    logic                     empty;

    modport master (
        output enable, add, add_addr_tag, add_addr_data, add_addr_RW,
               del, del_addr_tag, read_next, isRW_request, isRW_tag,
        input  add_ready, add_merged, del_hit, del_count, read_valid,
               read_addr_tag, read_addr_data, read_RW, isRW_valid, isRW_RW,
               full, empty
    );

    modport slave (
        input  enable, add, add_addr_tag, add_addr_data, add_addr_RW,
               del, del_addr_tag, read_next, isRW_request, isRW_tag,
        output add_ready, add_merged, del_hit, del_count, read_valid,
               read_addr_tag, read_addr_data, read_RW, isRW_valid, isRW_RW,
               full, empty
    );
endinterface
`default_nettype wire

// File: rtl/mshr_merge.sv
`default_nettype none
// ============================================================================
// Module      : mshr_merge
// Description : Miss status holding registers. Tracks outstanding misses,
//               merges secondary misses into an existing tag, issues un-sent
//               misses lowest index first and frees entries by tag on fill.
//               Optional MSHR_STATS_EN adds occupancy / merge_total outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module mshr_merge #(
    parameter int ADDR_TAG_BITS = 20,
    parameter int DATA_BITS     = 90,
    parameter int ENTRIES       = 8,
    parameter int IDX_BITS      = 3,
    parameter int MERGE_BITS    = 3
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mshr_merge_if.slave        bus
`ifdef MSHR_STATS_EN
    ,
    output logic [IDX_BITS:0]  occupancy,
    output logic [15:0]        merge_total
`endif
);

    localparam logic [MERGE_BITS-1:0] C_CNT_MAX = {MERGE_BITS{1'b1}};

    logic [ENTRIES-1:0]       r_valid;
    logic [ENTRIES-1:0]       r_issued;
    logic [ENTRIES-1:0]       r_rw;
    logic [ADDR_TAG_BITS-1:0] r_tag  [ENTRIES];
    logic [DATA_BITS-1:0]     r_data [ENTRIES];
    logic [MERGE_BITS-1:0]    r_cnt  [ENTRIES];

    logic [ENTRIES-1:0]    w_add_vec, w_del_vec, w_isrw_vec;
    logic                  w_free_found, w_cand_found;
    logic [IDX_BITS-1:0]   w_free_idx, w_cand_idx;
    logic [MERGE_BITS-1:0] w_del_cnt;
    logic                  w_isrw_rw;
    logic                  w_add_hit, w_add_ok, w_add_merge, w_add_alloc;
    logic                  w_del_ok, w_del_hit, w_pop;

    // Tag match vectors against the state held at the start of the cycle.
    always_comb begin
        w_add_vec  = '0;
        w_del_vec  = '0;
        w_isrw_vec = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_add_vec[i]  = r_valid[i] && (r_tag[i] == bus.add_addr_tag);
            w_del_vec[i]  = r_valid[i] && (r_tag[i] == bus.del_addr_tag);
            w_isrw_vec[i] = r_valid[i] && (r_tag[i] == bus.isRW_tag);
        end
    end

    // Lowest-index free slot and lowest-index un-issued candidate.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_cand_found = 1'b0;
        w_cand_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_BITS'(i);
            end
            if (r_valid[i] && !r_issued[i]) begin
                w_cand_found = 1'b1;
                w_cand_idx   = IDX_BITS'(i);
            end
        end
    end

    // Tags are unique, so at most one entry matches; OR-select its fields.
    always_comb begin
        w_del_cnt = '0;
        w_isrw_rw = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_del_vec[i])  w_del_cnt = w_del_cnt | r_cnt[i];
            if (w_isrw_vec[i]) w_isrw_rw = w_isrw_rw | r_rw[i];
        end
    end

    assign w_add_hit   = |w_add_vec;
    assign w_add_ok    = bus.enable && bus.add;
    assign w_add_merge = w_add_ok && w_add_hit;
    // A slot freed by a same-cycle del is not visible here: full is pre-cycle.
    assign w_add_alloc = w_add_ok && !w_add_hit && w_free_found;
    assign w_del_ok    = bus.enable && bus.del;
    assign w_del_hit   = w_del_ok && (|w_del_vec);
    assign w_pop       = bus.enable && bus.read_next && w_cand_found;

    assign bus.add_ready      = w_add_merge || w_add_alloc;
    assign bus.add_merged     = w_add_merge;
    assign bus.del_hit        = w_del_hit;
    assign bus.del_count      = w_del_hit ? w_del_cnt : '0;
    assign bus.read_valid     = w_cand_found;
    assign bus.read_addr_tag  = w_cand_found ? r_tag[w_cand_idx]  : '0;
    assign bus.read_addr_data = w_cand_found ? r_data[w_cand_idx] : '0;
    assign bus.read_RW        = w_cand_found ? r_rw[w_cand_idx]   : 1'b0;
    assign bus.isRW_valid     = bus.isRW_request && (|w_isrw_vec);
    assign bus.isRW_RW        = bus.isRW_valid ? w_isrw_rw : 1'b0;
    assign bus.full           = &r_valid;
    assign bus.empty          = ~|r_valid;

    // Entry update; del is applied last so it wins over merge and issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= '0;
            r_issued <= '0;
            r_rw     <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (w_add_merge && w_add_vec[i]) begin
                    r_rw[i] <= r_rw[i] | bus.add_addr_RW;
                    if (r_cnt[i] != C_CNT_MAX)
                        r_cnt[i] <= r_cnt[i] + MERGE_BITS'(1);
                end
                if (w_add_alloc && (w_free_idx == IDX_BITS'(i))) begin
                    r_valid[i]  <= 1'b1;
                    r_issued[i] <= 1'b0;
                    r_cnt[i]    <= '0;
                    r_rw[i]     <= bus.add_addr_RW;
                    r_tag[i]    <= bus.add_addr_tag;
                    r_data[i]   <= bus.add_addr_data;
                end
                if (w_pop && (w_cand_idx == IDX_BITS'(i)))
                    r_issued[i] <= 1'b1;
                if (w_del_ok && w_del_vec[i]) begin
                    r_valid[i]  <= 1'b0;
                    r_issued[i] <= 1'b0;
                    r_cnt[i]    <= '0;
                end
            end
        end
    end

`ifdef MSHR_STATS_EN
    logic [IDX_BITS:0] r_occupancy;
    logic [15:0]       r_merge_total;

    // Occupancy follows the valid vector; merge_total wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occupancy   <= '0;
            r_merge_total <= '0;
        end else begin
            r_occupancy   <= r_occupancy + (IDX_BITS+1)'(w_add_alloc)
                                         - (IDX_BITS+1)'(w_del_hit);
            r_merge_total <= r_merge_total + 16'(w_add_merge);
        end
    end

    assign occupancy   = r_occupancy;
    assign merge_total = r_merge_total;
`endif

endmodule
`default_nettype wire
